// File: rtl/aes_pkg.sv
// Shared AES-128 types, round count, Rcon lookup and FSM state encoding
// for the inverse key schedule.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Round constant for rounds 1..10; anything else maps to zero.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] val;
    case (idx)
      4'd1:    val = 8'h01;
      4'd2:    val = 8'h02;
      4'd3:    val = 8'h04;
      4'd4:    val = 8'h08;
      4'd5:    val = 8'h10;
      4'd6:    val = 8'h20;
      4'd7:    val = 8'h40;
      4'd8:    val = 8'h80;
      4'd9:    val = 8'h1b;
      4'd10:   val = 8'h36;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/aes_inv_key_expand_if.sv
// Start/key handshake bundle between the decryption controller (master)
// and the inverse key expander (slave).
interface aes_inv_key_expand_if;
  import aes_pkg::*;

  logic       start;
  key_t       last_key_in;
  logic       busy;
  logic       key_valid;
  logic       key_ready;
  key_t       key_out;
  logic [3:0] round_idx;
  logic       key_last;

  modport master (
    output start, last_key_in, key_ready,
    input  busy, key_valid, key_out, round_idx, key_last
  );

  modport slave (
    input  start, last_key_in, key_ready,
    output busy, key_valid, key_out, round_idx, key_last
  );

endinterface

// File: rtl/aes_inv_key_expand_sub_word.sv
// Forward AES SubWord: four parallel byte S-box lookups on a 32-bit word.
module aes_inv_key_expand_sub_word
  import aes_pkg::*;
(
  input  word_t word,
  output word_t sub
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/aes_inv_key_expand.sv
// Reverse AES-128 key schedule: loads round key 10 and streams round keys
// 10 down to 0, deriving each previous key combinationally from the current one.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start; outputs zero
// ST_RUN  | presenting key register / counter, step back on accept
module aes_inv_key_expand #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input logic            clk,
  input logic            rst,
  aes_inv_key_expand_if.slave kx
);
  import aes_pkg::*;

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_inv_key_expand supports only NUM_ROUNDS = 10");
  end

  state_t     state, state_nxt;
  key_t       key_q, key_nxt;
  logic [3:0] cnt_q, cnt_nxt;

  word_t w_e, w_f, w_g, w_h;
  word_t w_a, w_b, w_c, w_d;
  word_t sub_d;

  assign {w_e, w_f, w_g, w_h} = key_q;
  assign w_d = w_h ^ w_g;
  assign w_c = w_g ^ w_f;
  assign w_b = w_f ^ w_e;

  // S-box input is RotWord(d); d must be unrolled before the substitution.
  aes_inv_key_expand_sub_word u_sub_word (
    .word ({w_d[23:0], w_d[31:24]}),
    .sub  (sub_d)
  );

  assign w_a = w_e ^ sub_d ^ {rcon(cnt_q), 24'h000000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      key_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      key_q <= key_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_q;
    cnt_nxt   = cnt_q;
    case (state)
      ST_IDLE: begin
        if (kx.start) begin
          key_nxt   = kx.last_key_in;
          cnt_nxt   = 4'(NUM_ROUNDS);
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (kx.key_ready) begin
          if (cnt_q != 4'd0) begin
            key_nxt = {w_a, w_b, w_c, w_d};
            cnt_nxt = cnt_q - 4'd1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign kx.busy      = (state == ST_RUN);
  assign kx.key_valid = (state == ST_RUN);
  assign kx.key_out   = (state == ST_RUN) ? key_q : '0;
  assign kx.round_idx = (state == ST_RUN) ? cnt_q : 4'd0;
  assign kx.key_last  = (state == ST_RUN) && (cnt_q == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Bench for the inverse key expander: GF(2^8)-derived S-box model, scoreboard
// checked every cycle, plus directed FIPS-197 vectors and boundary scenarios.
module tb_aes_inv_key_expand;

  localparam logic [127:0] K10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9    = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K0    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_ALT = 128'h0123456789abcdeffedcba9876543210;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  aes_inv_key_expand_if kx ();

  aes_inv_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .kx  (kx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- reference model from GF(2^8) arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_m(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < i; j++) r = xt(r);
    return r;
  endfunction

  function automatic logic [31:0] sub_rot_m(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_m(r[31:24]), sbox_m(r[23:16]), sbox_m(r[15:8]), sbox_m(r[7:0])};
  endfunction

  // key of round i-1 from key of round i
  function automatic logic [127:0] prev_key(input logic [127:0] k, input int i);
    logic [31:0] e, f, g, h, a, b, c, d;
    {e, f, g, h} = k;
    d = h ^ g;
    c = g ^ f;
    b = f ^ e;
    a = e ^ sub_rot_m(d) ^ {rcon_m(i), 24'h0};
    return {a, b, c, d};
  endfunction

  // forward step: key of round i from key of round i-1
  function automatic logic [127:0] next_key(input logic [127:0] k, input int i);
    logic [31:0] e, f, g, h, a, b, c, d;
    {e, f, g, h} = k;
    a = e ^ sub_rot_m(h) ^ {rcon_m(i), 24'h0};
    b = f ^ a;
    c = g ^ b;
    d = h ^ c;
    return {a, b, c, d};
  endfunction

  // ---------------- scoreboard compare, every cycle ----------------
  logic [131:0] sb [$];

  always @(negedge clk) begin
    logic [127:0] k;
    if (rst) begin
      sb.delete();
      chk("rst_busy", kx.busy, 0);
      chk("rst_key_valid", kx.key_valid, 0);
      chk("rst_key_last", kx.key_last, 0);
      chk("rst_key_out", kx.key_out, 0);
      chk("rst_round_idx", kx.round_idx, 0);
    end else if (sb.size() != 0) begin
      chk("run_busy", kx.busy, 1);
      chk("run_key_valid", kx.key_valid, 1);
      chk("run_round_idx", kx.round_idx, sb[0][131:128]);
      chk("run_key_out", kx.key_out, sb[0][127:0]);
      chk("run_key_last", kx.key_last, sb[0][131:128] == 4'd0);
      if (kx.key_ready) void'(sb.pop_front());
    end else begin
      chk("idle_busy", kx.busy, 0);
      chk("idle_key_valid", kx.key_valid, 0);
      if (kx.start) begin
        k = kx.last_key_in;
        for (int r = 10; r >= 0; r--) begin
          sb.push_back({4'(r), k});
          if (r > 0) k = prev_key(k, r);
        end
      end
    end
  end

  // ---------------- directed driver ----------------
  logic [127:0] got [0:10];
  logic [127:0] mk  [0:10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always; 1: random ready; 2: 5-cycle stall at round 6.
  // pulse_alt: strobe start with K_ALT at round 7.
  task automatic collect(input int mode, input bit pulse_alt);
    int           n;
    int           stall;
    bit           done;
    bit           stalled_once;
    logic [127:0] snap_key;
    logic [3:0]   snap_idx;
    n = 0; stall = 0; done = 0; stalled_once = 0;
    snap_key = '0; snap_idx = '0;
    for (int i = 0; i <= 10; i++) got[i] = '0;
    while (!done && n < 200) begin
      if (kx.key_valid && kx.round_idx <= 4'd10) got[kx.round_idx] = kx.key_out;
      if (kx.key_valid && kx.key_last && kx.key_ready) done = 1;
      kx.start = 1'b0;
      if (pulse_alt && kx.key_valid && kx.round_idx == 4'd7) begin
        kx.start = 1'b1;
        kx.last_key_in = K_ALT;
      end
      if (stall > 0) begin
        chk("stall_key_out", kx.key_out, snap_key);
        chk("stall_round_idx", kx.round_idx, snap_idx);
        stall--;
        kx.key_ready = (stall == 0);
      end else if (mode == 2 && !stalled_once && kx.key_valid && kx.round_idx == 4'd6
                   && !kx.key_ready) begin
        stalled_once = 1;
      end else if (mode == 2 && !stalled_once && kx.key_valid && kx.round_idx == 4'd6) begin
        stalled_once = 1;
        stall = 5;
        snap_key = kx.key_out;
        snap_idx = kx.round_idx;
        kx.key_ready = 1'b0;
      end else if (mode == 1) begin
        kx.key_ready = 1'($urandom_range(0, 1));
      end else begin
        kx.key_ready = 1'b1;
      end
      if (!done) begin
        step();
        n++;
      end
    end
    chk("collect_completed", done, 1);
    kx.start = 1'b0;
    kx.key_ready = 1'b1;
    step();
    chk("busy_after_last", kx.busy, 0);
    chk("valid_after_last", kx.key_valid, 0);
  endtask

  task automatic check_seq(input string tag);
    for (int r = 0; r <= 10; r++) chk($sformatf("%s_round%0d", tag, r), got[r], mk[r]);
  endtask

  task automatic launch(input logic [127:0] k);
    kx.last_key_in = k;
    kx.start = 1'b1;
    step();
    kx.start = 1'b0;
  endtask

  initial begin
    int n;
    logic [127:0] k;
    rst = 1'b1;
    kx.start = 1'b0;
    kx.key_ready = 1'b0;
    kx.last_key_in = '0;

    // pin the model itself
    chk("model_sbox_00", sbox_m(8'h00), 8'h63);
    chk("model_sbox_53", sbox_m(8'h53), 8'hed);
    chk("model_rcon_10", rcon_m(10), 8'h36);
    mk[10] = K10;
    for (int r = 10; r > 0; r--) mk[r-1] = prev_key(mk[r], r);
    chk("model_round9", mk[9], K9);
    chk("model_round1", mk[1], K1);
    chk("model_round0", mk[0], K0);
    k = mk[0];
    for (int i = 1; i <= 10; i++) k = next_key(k, i);
    chk("model_roundtrip", k, K10);

    repeat (3) step();
    rst = 1'b0;
    step();

    // full-throughput FIPS run; ready is already high before start
    kx.key_ready = 1'b1;
    launch(K10);
    chk("first_beat_valid", kx.key_valid, 1);
    chk("first_beat_idx", kx.round_idx, 10);
    collect(0, 0);
    chk("fips_round10", got[10], K10);
    chk("fips_round9", got[9], K9);
    chk("fips_round1", got[1], K1);
    chk("fips_round0", got[0], K0);

    // 5-cycle stall at round 6
    launch(K10);
    collect(2, 0);
    check_seq("stall");

    // random backpressure
    launch(K10);
    collect(1, 0);
    check_seq("random");

    // start with a different key while busy
    launch(K10);
    collect(0, 1);
    check_seq("start_busy");

    // reset at round 4, then a clean rerun
    launch(K10);
    n = 0;
    while (!(kx.key_valid && kx.round_idx == 4'd4) && n < 50) begin
      step();
      n++;
    end
    chk("reached_round4", kx.round_idx, 4);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", kx.busy, 0);
    chk("async_rst_valid", kx.key_valid, 0);
    chk("async_rst_key_out", kx.key_out, 0);
    chk("async_rst_round_idx", kx.round_idx, 0);
    chk("async_rst_key_last", kx.key_last, 0);
    step();
    rst = 1'b0;
    step();
    launch(K10);
    collect(0, 0);
    check_seq("after_rst");

    // back-to-back with start held high
    kx.last_key_in = K10;
    kx.start = 1'b1;
    step();
    n = 0;
    while (!(kx.key_valid && kx.key_last) && n < 50) begin
      step();
      n++;
    end
    chk("b2b_first_last", kx.key_last, 1);
    step();
    chk("b2b_gap_valid", kx.key_valid, 0);
    step();
    kx.start = 1'b0;
    chk("b2b_restart_valid", kx.key_valid, 1);
    chk("b2b_restart_idx", kx.round_idx, 10);
    chk("b2b_restart_key", kx.key_out, K10);
    collect(0, 0);
    check_seq("b2b");

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
